// File: rtl/inv_mix_column.sv
// ============================================================================
//  Module   : inv_mix_column
//  Function : Byte-serial AES InvMixColumns; one shared GF(2^8) multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_mix_column (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] d_in,
   output logic [7:0] d0_out,
   output logic [7:0] d1_out,
   output logic [7:0] d2_out,
   output logic [7:0] d3_out,
   output logic       valid
);

   localparam logic [1:0] C_LAST = 2'd3;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [1:0]       k_q, k_d;
   logic [3:0][7:0]  acc_q, acc_d;
   logic [3:0][7:0]  dout_q, dout_d;
   logic             valid_q, valid_d;

   logic [7:0]       w_x2, w_x4, w_x8;
   logic [3:0][7:0]  w_prod;
   logic [3:0][7:0]  w_term;

   assign w_x2 = xtime(d_in);
   assign w_x4 = xtime(w_x2);
   assign w_x8 = xtime(w_x4);

   // Indexed by (k - row) mod 4: coefficients 0e, 0b, 0d, 09.
   assign w_prod[0] = w_x8 ^ w_x4 ^ w_x2;
   assign w_prod[1] = w_x8 ^ w_x2 ^ d_in;
   assign w_prod[2] = w_x8 ^ w_x4 ^ d_in;
   assign w_prod[3] = w_x8 ^ d_in;

   for (genvar i = 0; i < 4; i++) begin : g_row
      logic [1:0] w_idx;
      assign w_idx     = k_q - 2'(i);
      assign w_term[i] = w_prod[w_idx];
   end

   always_comb begin
      k_d     = k_q;
      acc_d   = acc_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      if (en) begin
         if (k_q == C_LAST) begin
            dout_d  = acc_q ^ w_term;
            acc_d   = '0;
            k_d     = 2'd0;
            valid_d = 1'b1;
         end else begin
            acc_d = acc_q ^ w_term;
            k_d   = k_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q     <= 2'd0;
         acc_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         k_q     <= k_d;
         acc_q   <= acc_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign d0_out = dout_q[0];
   assign d1_out = dout_q[1];
   assign d2_out = dout_q[2];
   assign d3_out = dout_q[3];
   assign valid  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_mix_column.sv
// ============================================================================
//  Module   : tb_inv_mix_column
//  Function : Self-checking bench for inv_mix_column with a GF(2^8) model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_mix_column;

   typedef logic [3:0][7:0] col_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] d_in;
   logic [7:0] d0_out, d1_out, d2_out, d3_out;
   logic       valid;

   int checks = 0;
   int errors = 0;

   inv_mix_column dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .d_in   (d_in),
      .d0_out (d0_out),
      .d1_out (d1_out),
      .d2_out (d2_out),
      .d3_out (d3_out),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Circulant matrix product: out[i] = XOR_j coef[(j-i) mod 4] * col[j].
   function automatic col_t circ(input col_t c, input col_t coef);
      col_t r = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            r[i] ^= gmul(c[j], coef[(j - i + 4) % 4]);
      return r;
   endfunction

   function automatic col_t mk(input logic [7:0] b0, b1, b2, b3);
      return {b3, b2, b1, b0};
   endfunction

   function automatic col_t mix_model(input col_t c);
      return circ(c, mk(8'h02, 8'h03, 8'h01, 8'h01));
   endfunction

   function automatic col_t inv_model(input col_t c);
      return circ(c, mk(8'h0e, 8'h0b, 8'h0d, 8'h09));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {d3_out, d2_out, d1_out, d0_out};
   endfunction

   task automatic cyc(input logic e, input logic [7:0] d);
      en   = e;
      d_in = d;
      @(posedge clk);
      #1;
   endtask

   // Feeds a column with random idle gaps up to maxgap; returns with the
   // sample point just after the last byte. nv counts valids seen earlier.
   task automatic run_col(input col_t c, input int maxgap, output int nv);
      nv = 0;
      for (int k = 0; k < 4; k++) begin
         int g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         for (int n = 0; n < g; n++) begin
            cyc(1'b0, 8'h00);
            if (valid) nv++;
         end
         cyc(1'b1, c[k]);
         if (k < 3 && valid) nv++;
      end
   endtask

   initial begin
      int   nv;
      col_t orig, mixed, prev;

      rst = 1'b1; en = 1'b0; d_in = 8'h00;
      #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_out", outs(), 32'h0);
      chk("reset_valid", {31'b0, valid}, 32'h0);
      for (int n = 0; n < 3; n++) cyc(1'b0, 8'hff);
      chk("idle_out", outs(), 32'h0);
      chk("idle_valid", {31'b0, valid}, 32'h0);

      // Back-to-back columns
      run_col(mk(8'h8e, 8'h4d, 8'ha1, 8'hbc), 0, nv);
      chk("b2b1_early_valid", nv, 0);
      chk("b2b1_valid", {31'b0, valid}, 32'h1);
      chk("b2b1_out", outs(), mk(8'hdb, 8'h13, 8'h53, 8'h45));
      run_col(mk(8'h9f, 8'hdc, 8'h58, 8'h9d), 0, nv);
      chk("b2b2_early_valid", nv, 0);
      chk("b2b2_valid", {31'b0, valid}, 32'h1);
      chk("b2b2_out", outs(), mk(8'hf2, 8'h0a, 8'h22, 8'h5c));
      cyc(1'b0, 8'h00);
      chk("pulse_width", {31'b0, valid}, 32'h0);
      chk("hold_out", outs(), mk(8'hf2, 8'h0a, 8'h22, 8'h5c));

      // Gapped: d5, idle x2, d5, d7, idle, d6
      nv = 0;
      cyc(1'b1, 8'hd5); nv += int'(valid);
      cyc(1'b0, 8'h00); nv += int'(valid);
      cyc(1'b0, 8'h00); nv += int'(valid);
      cyc(1'b1, 8'hd5); nv += int'(valid);
      cyc(1'b1, 8'hd7); nv += int'(valid);
      cyc(1'b0, 8'h00); nv += int'(valid);
      chk("gap_early_valid", nv, 0);
      chk("gap_hold_out", outs(), mk(8'hf2, 8'h0a, 8'h22, 8'h5c));
      cyc(1'b1, 8'hd6);
      chk("gap_valid", {31'b0, valid}, 32'h1);
      chk("gap_out", outs(), mk(8'hd4, 8'hd4, 8'hd4, 8'hd5));

      // Identity columns
      run_col(mk(8'h01, 8'h01, 8'h01, 8'h01), 0, nv);
      chk("ident01_out", outs(), mk(8'h01, 8'h01, 8'h01, 8'h01));
      run_col(mk(8'hc6, 8'hc6, 8'hc6, 8'hc6), 0, nv);
      chk("identc6_out", outs(), mk(8'hc6, 8'hc6, 8'hc6, 8'hc6));

      // Reset mid-column, with en held high during reset
      cyc(1'b1, 8'h8e);
      cyc(1'b1, 8'h4d);
      chk("mid_valid", {31'b0, valid}, 32'h0);
      rst = 1'b1;
      cyc(1'b1, 8'ha1);
      rst = 1'b0;
      chk("mid_rst_valid", {31'b0, valid}, 32'h0);
      chk("mid_rst_out", outs(), 32'h0);
      run_col(mk(8'h4d, 8'h7e, 8'hbd, 8'hf8), 0, nv);
      chk("post_rst_early_valid", nv, 0);
      chk("post_rst_valid", {31'b0, valid}, 32'h1);
      chk("post_rst_out", outs(), mk(8'h2d, 8'h26, 8'h31, 8'h4c));

      // Round trip on random columns with random gaps
      for (int t = 0; t < 16; t++) begin
         orig  = col_t'($urandom);
         mixed = mix_model(orig);
         run_col(mixed, (t < 8) ? 0 : 2, nv);
         chk($sformatf("rt%0d_early_valid", t), nv, 0);
         chk($sformatf("rt%0d_valid", t), {31'b0, valid}, 32'h1);
         chk($sformatf("rt%0d_out", t), outs(), orig);
         chk($sformatf("rt%0d_model", t), outs(), inv_model(mixed));
      end

      // Random direct columns against the inverse model
      for (int t = 0; t < 8; t++) begin
         orig = col_t'($urandom);
         prev = inv_model(orig);
         run_col(orig, 1, nv);
         chk($sformatf("rnd%0d_out", t), outs(), prev);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
